// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the fetch front end and its branch predictor.
//   - 2-bit saturating counter encodings and the counter value after reset
//   - helpers that split a PC into predictor index and tag
//   - the saturating counter step
// The helpers work on 32-bit values, so PCs up to 32 bits wide are supported.
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [1:0] SNT       = 2'b00;
    localparam logic [1:0] WNT       = 2'b01;
    localparam logic [1:0] WT        = 2'b10;
    localparam logic [1:0] ST        = 2'b11;
    localparam logic [1:0] CTR_RESET = WNT;

    // Index bits sit directly above the instruction alignment bits.
    function automatic logic [31:0] pc_index(input logic [31:0] pc,
                                             input int unsigned shift,
                                             input int unsigned idxW);
        return (pc >> shift) & ((32'd1 << idxW) - 32'd1);
    endfunction

    // The tag is everything above the index field.
    function automatic logic [31:0] pc_tag(input logic [31:0] pc,
                                           input int unsigned shift,
                                           input int unsigned idxW);
        return pc >> (shift + idxW);
    endfunction

    // Saturating step: moves toward ST when taken, toward SNT otherwise.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr,
                                            input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr + 2'd1;
        end
        return (ctr == SNT) ? SNT : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/bp_table.sv
// ---------------------------------------------------------------------------
// bp_table
// Direct-mapped, tagged predictor storage: per entry a valid bit, tag,
// branch target and 2-bit saturating counter.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rd_pc             PC looked up combinationally
//   rd_hit            entry valid and tag matches rd_pc
//   rd_ctr            counter of the entry (0 on miss)
//   rd_target         stored target (0 on miss)
//   upd_pc            PC of the branch being resolved
//   upd_taken         resolved outcome
//   wen_bht           step the counter (only when the entry matches)
//   wen_btb           write valid/tag/target, allocating if needed
//   upd_target        target written by wen_btb
// Reads see the contents before any update in the same cycle.
// ---------------------------------------------------------------------------
module bp_table
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int IDX_W  = 3,
    parameter int SHIFT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_pc,
    output logic              rd_hit,
    output logic [1:0]        rd_ctr,
    output logic [ADDR_W-1:0] rd_target,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic              wen_bht,
    input  logic              wen_btb,
    input  logic [ADDR_W-1:0] upd_target
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam int TAG_W = ADDR_W - IDX_W - SHIFT;

    logic              valid_q  [DEPTH];
    logic [TAG_W-1:0]  tag_q    [DEPTH];
    logic [ADDR_W-1:0] target_q [DEPTH];
    logic [1:0]        ctr_q    [DEPTH];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_match;
    logic [1:0]       ctr_d;

    // Read port: zero-cycle lookup; misses report zeros for counter and target.
    always_comb begin
        rd_idx    = IDX_W'(pc_index(32'(rd_pc), SHIFT, IDX_W));
        rd_tag    = TAG_W'(pc_tag(32'(rd_pc), SHIFT, IDX_W));
        rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_ctr    = rd_hit ? ctr_q[rd_idx] : 2'b00;
        rd_target = rd_hit ? target_q[rd_idx] : '0;
    end

    // Update port: decide the new counter value for the addressed entry.
    // A matching entry steps; a fresh allocation starts weakly biased toward
    // the outcome when the outcome is known, otherwise at the reset value.
    always_comb begin
        upd_idx   = IDX_W'(pc_index(32'(upd_pc), SHIFT, IDX_W));
        upd_tag   = TAG_W'(pc_tag(32'(upd_pc), SHIFT, IDX_W));
        upd_match = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        ctr_d     = ctr_q[upd_idx];
        if (upd_match) begin
            if (wen_bht) begin
                ctr_d = ctr_step(ctr_q[upd_idx], upd_taken);
            end
        end else if (wen_btb) begin
            if (wen_bht) begin
                ctr_d = upd_taken ? WT : WNT;
            end else begin
                ctr_d = CTR_RESET;
            end
        end
    end

    // Table state; reset empties every entry and drops any pending update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_RESET;
            end
        end else begin
            if (wen_btb) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= upd_target;
            end
            if (wen_btb || (wen_bht && upd_match)) begin
                ctr_q[upd_idx] <= ctr_d;
            end
        end
    end

endmodule

// File: rtl/fetch_bp_param.sv
// ---------------------------------------------------------------------------
// fetch_bp_param
// Instruction-fetch front end: PC register, sequential adder, next-PC select
// and a tagged direct-mapped dynamic branch predictor.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   stall                hold the PC (hazard unit)
//   redirect             load redirect_target, overriding stall
//   redirect_target      corrected next PC
//   upd_pc, upd_taken    resolved branch PC and outcome
//   wen_bht, wen_btb     counter / BTB write enables
//   upd_target           resolved branch target
//   imem_addr, imem_en   instruction memory address and read enable
//   pc_curr, pc_next     current PC and PC + INST_BYTES
//   prediction           counter for pc_curr (0 on miss)
//   pred_hit             predictor hit for pc_curr
//   predicted_target     BTB target for pc_curr (0 on miss)
// ---------------------------------------------------------------------------
module fetch_bp_param
    import fetch_pkg::*;
#(
    parameter int              ADDR_W     = 16,
    parameter int              IDX_W      = 3,
    parameter int              INST_BYTES = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic              wen_bht,
    input  logic              wen_btb,
    input  logic [ADDR_W-1:0] upd_target,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_en,
    output logic [ADDR_W-1:0] pc_curr,
    output logic [ADDR_W-1:0] pc_next,
    output logic [1:0]        prediction,
    output logic              pred_hit,
    output logic [ADDR_W-1:0] predicted_target
);

    localparam int SHIFT = $clog2(INST_BYTES);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic              pred_taken;

    bp_table #(
        .ADDR_W (ADDR_W),
        .IDX_W  (IDX_W),
        .SHIFT  (SHIFT)
    ) u_bp_table (
        .clk        (clk),
        .rst        (rst),
        .rd_pc      (pc_q),
        .rd_hit     (pred_hit),
        .rd_ctr     (prediction),
        .rd_target  (predicted_target),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .wen_bht    (wen_bht),
        .wen_btb    (wen_btb),
        .upd_target (upd_target)
    );

    // Sequential path wraps naturally at the PC width.
    assign pc_next    = pc_q + ADDR_W'(INST_BYTES);
    assign pred_taken = pred_hit & prediction[1];
    assign pc_curr    = pc_q;
    assign imem_addr  = pc_q;
    assign imem_en    = ~stall;

    // Next-PC select: a redirect is a flush and wins even over a stall.
    always_comb begin
        pc_d = pc_next;
        if (redirect) begin
            pc_d = redirect_target;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = predicted_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_bp_param.sv
// ---------------------------------------------------------------------------
// tb_fetch_bp_param
// Directed bench for fetch_bp_param with default parameters
// (ADDR_W=16, IDX_W=3, INST_BYTES=2, RESET_PC=0).
// ---------------------------------------------------------------------------
module tb_fetch_bp_param;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_target;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic        wen_bht;
    logic        wen_btb;
    logic [15:0] upd_target;
    logic [15:0] imem_addr;
    logic        imem_en;
    logic [15:0] pc_curr;
    logic [15:0] pc_next;
    logic [1:0]  prediction;
    logic        pred_hit;
    logic [15:0] predicted_target;

    int testsRun;
    int testsFailed;

    fetch_bp_param #(
        .ADDR_W     (16),
        .IDX_W      (3),
        .INST_BYTES (2),
        .RESET_PC   (16'h0000)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_target  (redirect_target),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .wen_bht          (wen_bht),
        .wen_btb          (wen_btb),
        .upd_target       (upd_target),
        .imem_addr        (imem_addr),
        .imem_en          (imem_en),
        .pc_curr          (pc_curr),
        .pc_next          (pc_next),
        .prediction       (prediction),
        .pred_hit         (pred_hit),
        .predicted_target (predicted_target)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    // One clock edge; outputs settle and are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_upd();
        wen_bht    = 1'b0;
        wen_btb    = 1'b0;
        upd_taken  = 1'b0;
        upd_pc     = 16'h0000;
        upd_target = 16'h0000;
    endtask

    // Force the PC to a known value through a redirect.
    task automatic goto_pc(input logic [15:0] addr);
        redirect        = 1'b1;
        redirect_target = addr;
        step();
        redirect        = 1'b0;
        redirect_target = 16'h0000;
    endtask

    task automatic check_pc(input string name, input logic [15:0] exp);
        testsRun++;
        if (pc_curr !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: pc_curr=%h expected %h", name, pc_curr, exp);
        end
    endtask

    task automatic check_pred(input string name, input logic expHit,
                              input logic [1:0] expCtr, input logic [15:0] expTgt);
        testsRun++;
        if (pred_hit !== expHit || prediction !== expCtr || predicted_target !== expTgt) begin
            testsFailed++;
            $display("[TB] FAIL %s: hit=%b ctr=%b tgt=%h expected hit=%b ctr=%b tgt=%h",
                     name, pred_hit, prediction, predicted_target, expHit, expCtr, expTgt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        check_pc("reset_pc", 16'h0000);
        check_pred("reset_empty", 1'b0, 2'b00, 16'h0000);
        testsRun++;
        if (pc_next !== 16'h0002 || imem_addr !== 16'h0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_next: pc_next=%h imem_addr=%h expected 0002 0000",
                     pc_next, imem_addr);
        end
        rst = 1'b0;
        step();
        check_pc("run_2", 16'h0002);
        step();
        check_pc("run_4", 16'h0004);
        step();
        check_pc("run_6", 16'h0006);
        // Asynchronous assertion in the middle of a cycle.
        #2;
        rst = 1'b1;
        #1;
        check_pc("async_reset", 16'h0000);
        #1;
        rst = 1'b0;
        step();
        check_pc("after_async_2", 16'h0002);
    endtask

    task automatic test_allocate();
        wen_btb    = 1'b1;
        wen_bht    = 1'b1;
        upd_pc     = 16'h0004;
        upd_target = 16'h0020;
        upd_taken  = 1'b1;
        goto_pc(16'h0040);
        clear_upd();
        check_pred("alloc_other_pc", 1'b0, 2'b00, 16'h0000);
        goto_pc(16'h0004);
        check_pred("alloc_hit", 1'b1, 2'b10, 16'h0020);
        step();
        check_pc("alloc_follow_target", 16'h0020);
        step();
        check_pc("alloc_after_target", 16'h0022);
    endtask

    task automatic test_saturation();
        logic [1:0] expCtr [8];
        expCtr = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};
        goto_pc(16'h0004);
        stall = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wen_bht   = 1'b1;
            upd_pc    = 16'h0004;
            upd_taken = (i < 4);
            step();
            check_pred($sformatf("sat_step_%0d", i), 1'b1, expCtr[i], 16'h0020);
        end
        clear_upd();
        testsRun++;
        if (pc_curr !== 16'h0004 || imem_en !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL sat_stall_hold: pc_curr=%h imem_en=%b expected 0004 0",
                     pc_curr, imem_en);
        end
        stall = 1'b0;
        step();
        check_pc("sat_fallthrough", 16'h0006);
    endtask

    task automatic test_aliasing();
        goto_pc(16'h0014);
        check_pred("alias_miss", 1'b0, 2'b00, 16'h0000);
        step();
        check_pc("alias_next", 16'h0016);
        wen_bht   = 1'b1;
        upd_pc    = 16'h0014;
        upd_taken = 1'b1;
        step();
        step();
        clear_upd();
        goto_pc(16'h0004);
        check_pred("alias_untouched", 1'b1, 2'b00, 16'h0020);
    endtask

    task automatic test_priority();
        goto_pc(16'h0030);
        stall           = 1'b1;
        redirect        = 1'b1;
        redirect_target = 16'h0100;
        step();
        redirect        = 1'b0;
        check_pc("redirect_over_stall", 16'h0100);
        step();
        check_pc("stall_hold", 16'h0100);
        testsRun++;
        if (imem_en !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL stall_imem_en: imem_en=%b expected 0", imem_en);
        end
        stall = 1'b0;
        #1;
        testsRun++;
        if (imem_en !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL run_imem_en: imem_en=%b expected 1", imem_en);
        end
        step();
        check_pc("stall_release", 16'h0102);
    endtask

    task automatic test_new_alloc_not_taken();
        wen_btb    = 1'b1;
        wen_bht    = 1'b1;
        upd_pc     = 16'h0008;
        upd_target = 16'h0050;
        upd_taken  = 1'b0;
        goto_pc(16'h0200);
        clear_upd();
        goto_pc(16'h0008);
        check_pred("alloc_nt_hit", 1'b1, 2'b01, 16'h0050);
        step();
        check_pc("alloc_nt_fallthrough", 16'h000A);
    endtask

    task automatic test_wrap();
        goto_pc(16'hFFFE);
        testsRun++;
        if (pc_next !== 16'h0000 || pred_hit !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL wrap_next: pc_next=%h hit=%b expected 0000 0", pc_next, pred_hit);
        end
        step();
        check_pc("wrap_load", 16'h0000);
    endtask

    task automatic test_reset_drops_update();
        wen_btb    = 1'b1;
        wen_bht    = 1'b1;
        upd_pc     = 16'h000C;
        upd_target = 16'h0070;
        upd_taken  = 1'b1;
        #2;
        rst = 1'b1;
        step();
        clear_upd();
        rst = 1'b0;
        goto_pc(16'h000C);
        check_pred("reset_dropped_update", 1'b0, 2'b00, 16'h0000);
        goto_pc(16'h0004);
        check_pred("reset_cleared_entry", 1'b0, 2'b00, 16'h0000);
    endtask

    initial begin
        testsRun        = 0;
        testsFailed     = 0;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_target = 16'h0000;
        clear_upd();
        rst = 1'b1;
        test_reset();
        test_allocate();
        test_saturation();
        test_aliasing();
        test_priority();
        test_new_alloc_not_taken();
        test_wrap();
        test_reset_drops_update();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
